mpu_i2c_target: RTL and testbench

I2C target (responder) that emulates the MPU-6050 register interface seen by the on-board I2C initiator. It sits on the sensor bus in place of, or alongside, the physical IMU, serving accelerometer/temperature/gyro bytes from a parallel sample input and accepting configuration writes. It is used for closed-loop bring-up and simulation of the balance controller without real sensor hardware.

---
 rtl/mpu_i2c_target_if.sv | 14 +
 rtl/mpu_i2c_target.sv | 232 +++++++++++++++++++++++
 tb/tb_mpu_i2c_target.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_i2c_target_if.sv
// mpu_i2c_target_if
//   I2C bus-side signals of the MPU-6050 emulating target.
//   scl_i    : I2C clock seen on the bus (asynchronous to clk_i)
//   sda_i    : I2C data seen on the bus (asynchronous to clk_i)
//   sda_oe_o : 1 = target pulls SDA low, 0 = released (open-drain pad outside)
//   Modports: slave (the target), master (the bus side / initiator model).
interface mpu_i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe_o;

  modport slave  (input  scl_i, input  sda_i, output sda_oe_o);
  modport master (output scl_i, output sda_i, input  sda_oe_o);
endinterface

// File: rtl/mpu_i2c_target.sv
// mpu_i2c_target
//   I2C target emulating the MPU-6050 register interface. Serves 14 sensor
//   bytes (0x3B..0x48) from a shadow/burst-buffer pair, PWR_MGMT_1 (0x6B,
//   read/write) and WHO_AM_I (0x75). Other addresses read 0x00 and discard
//   writes.
//   Ports:
//     clk_i, rst_ni  : system clock (>= 20x SCL), async active-low reset
//     bus            : I2C scl/sda inputs and open-drain sda enable
//     sample_i       : 14 sensor bytes, [111:104] = reg 0x3B .. [7:0] = 0x48
//     sample_we_i    : load sample_i into the shadow register file
//     pwr_mgmt_o     : current value of register 0x6B
//     busy_o         : matched-address transaction in progress
//     wr_strobe_o    : one-cycle pulse per accepted data-byte write
module mpu_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I = 8'h68,
  parameter logic [7:0] PWR_RST  = 8'h40
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mpu_i2c_target_if.slave bus,
  input  logic [111:0]   sample_i,
  input  logic           sample_we_i,
  output logic [7:0]     pwr_mgmt_o,
  output logic           busy_o,
  output logic           wr_strobe_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  // Synchronizers plus one edge-history stage
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= bus.sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_ptr, w_ptr_nxt;
  logic          r_oe, w_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_strobe, w_strobe_nxt;
  logic [7:0]    r_pwr, w_pwr_nxt;
  logic          w_buf_load;
  logic [111:0]  r_shadow, r_buf, w_buf_src;
  logic [7:0]    w_rd_byte, w_rd_first;

  // A shadow load in the same cycle as the burst copy wins
  assign w_buf_src = sample_we_i ? sample_i : r_shadow;

  function automatic logic [7:0] f_reg_byte(input logic [7:0]   ptr,
                                            input logic [111:0] src,
                                            input logic [7:0]   pwr);
    logic [3:0] off;
    logic [6:0] base;
    // 0x3B..0x48 map to offsets 0..13 using only the low nibble
    off  = ptr[3:0] - 4'hB;
    base = 7'd111 - {off, 3'b000};
    if (ptr >= 8'h3B && ptr <= 8'h48) return src[base -: 8];
    else if (ptr == 8'h6B)            return pwr;
    else if (ptr == 8'h75)            return WHO_AM_I;
    else                              return '0;
  endfunction

  assign w_rd_byte  = f_reg_byte(r_ptr, r_buf, r_pwr);
  // First bit of a burst is driven in the same cycle the buffer is loaded
  assign w_rd_first = f_reg_byte(r_ptr, w_buf_src, r_pwr);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_oe_nxt     = r_oe;
    w_busy_nxt   = r_busy;
    w_pwr_nxt    = r_pwr;
    w_strobe_nxt = 1'b0;
    w_buf_load   = 1'b0;
    if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_REG, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], r_sda_s2};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            // ACK goes out on the falling edge after the 8th bit
            w_cnt_nxt = '0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_oe_nxt    = 1'b1;
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end else begin
              w_oe_nxt    = 1'b1;
              w_state_nxt = (r_state == S_REG) ? S_REG_ACK : S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = '0;
            if (r_shift[0]) begin
              w_state_nxt = S_RDATA;
              w_buf_load  = 1'b1;
              w_oe_nxt    = ~w_rd_first[7];
            end else begin
              w_state_nxt = S_REG;
              w_oe_nxt    = 1'b0;
            end
          end
        end
        S_REG_ACK: begin
          if (w_scl_fall) begin
            w_ptr_nxt   = r_shift;
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_WDATA;
          end
        end
        S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_oe_nxt     = 1'b0;
            w_strobe_nxt = 1'b1;
            if (r_ptr == 8'h6B) w_pwr_nxt = r_shift;
            w_ptr_nxt    = r_ptr + 8'd1;
            w_state_nxt  = S_WDATA;
          end
        end
        S_RDATA: begin
          // r_cnt counts bits already clocked out; bit 7 is pre-driven
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_ptr_nxt   = r_ptr + 8'd1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_RDATA_ACK;
            end else begin
              w_oe_nxt = ~w_rd_byte[3'd7 - r_cnt[2:0]];
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_cnt_nxt = '0;
            if (r_sda_s2) begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_RDATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_pwr    <= PWR_RST;
      r_shadow <= '0;
      r_buf    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_oe     <= w_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_strobe <= w_strobe_nxt;
      r_pwr    <= w_pwr_nxt;
      if (sample_we_i) r_shadow <= sample_i;
      if (w_buf_load)  r_buf    <= w_buf_src;
    end
  end

  assign bus.sda_oe_o = r_oe;
  assign pwr_mgmt_o   = r_pwr;
  assign busy_o       = r_busy;
  assign wr_strobe_o  = r_strobe;

endmodule

// File: tb/tb_mpu_i2c_target.sv
// tb_mpu_i2c_target
//   Bit-banged I2C initiator driving mpu_i2c_target, with a transaction-level
//   register-map model (pointer, PWR_MGMT, shadow and burst copy) that supplies
//   every expected value.
`timescale 1ns/1ps
module tb_mpu_i2c_target;
  localparam int unsigned Q = 5;  // clk cycles per quarter SCL period

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_scl = 1'b1;
  logic         m_sda = 1'b1;
  logic [111:0] sample = '0;
  logic         sample_we = 1'b0;
  logic [7:0]   pwr;
  logic         busy;
  logic         strobe;

  mpu_i2c_target_if bus();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe_o;

  mpu_i2c_target #(.DEV_ADDR(7'h68), .WHO_AM_I(8'h68), .PWR_RST(8'h40)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .sample_i    (sample),
    .sample_we_i (sample_we),
    .pwr_mgmt_o  (pwr),
    .busy_o      (busy),
    .wr_strobe_o (strobe)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_shadow [14];
  logic [7:0]  m_buf [14];
  logic [7:0]  m_pwr = 8'h40;
  logic [7:0]  m_ptr = 8'h00;
  int unsigned m_strobes = 0;

  function automatic logic [7:0] model_reg(input logic [7:0] a);
    int idx;
    idx = int'(a) - 'h3B;
    if (idx >= 0 && idx <= 13) return m_buf[idx];
    if (a == 8'h6B) return m_pwr;
    if (a == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  task automatic model_reset;
    for (int k = 0; k < 14; k++) begin
      m_shadow[k] = 8'h00;
      m_buf[k]    = 8'h00;
    end
    m_pwr = 8'h40;
    m_ptr = 8'h00;
  endtask

  // ---------------- monitors ----------------
  logic        prev_oe = 1'b0;
  logic        prev_strobe = 1'b0;
  int unsigned oe_viol = 0;
  int unsigned strobe_pulses = 0;
  int unsigned strobe_cycles = 0;
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.sda_oe_o !== prev_oe && m_scl) oe_viol++;
    prev_oe = bus.sda_oe_o;
    if (bus.sda_oe_o) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (strobe) strobe_cycles++;
    if (strobe && !prev_strobe) strobe_pulses++;
    prev_strobe = strobe;
  end

  // ---------------- bus primitives ----------------
  task automatic wait_q(input int unsigned n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b1; wait_q(2);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_q(1);
    m_scl = 1'b1; wait_q(2);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    b = bus.sda_i; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic pulse_sample;
    for (int k = 0; k < 14; k++) sample[111 - 8*k -: 8] = m_shadow[k];
    sample_we = 1'b1;
    @(negedge clk);
    sample_we = 1'b0;
  endtask

  // ---------------- transactions ----------------
  logic [7:0] wdata_q [$];

  task automatic txn_write(input logic [7:0] reg_a);
    logic ack;
    i2c_start;
    write_byte(8'hD0, ack);
    check_eq("wr_addr_ack", 32'(ack), 0);
    check_eq("wr_busy", 32'(busy), 1);
    write_byte(reg_a, ack);
    check_eq("wr_reg_ack", 32'(ack), 0);
    m_ptr = reg_a;
    foreach (wdata_q[i]) begin
      write_byte(wdata_q[i], ack);
      check_eq("wr_data_ack", 32'(ack), 0);
      if (m_ptr == 8'h6B) m_pwr = wdata_q[i];
      m_strobes++;
      m_ptr = m_ptr + 8'd1;
      check_eq("pwr_mgmt", 32'(pwr), 32'(m_pwr));
      check_eq("strobe_count", strobe_pulses, m_strobes);
    end
    i2c_stop;
    check_eq("wr_busy_stop", 32'(busy), 0);
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] reg_a,
                          input int unsigned n, input bit mid_update);
    logic       ack;
    logic [7:0] d;
    i2c_start;
    if (set_ptr) begin
      write_byte(8'hD0, ack);
      check_eq("rd_waddr_ack", 32'(ack), 0);
      write_byte(reg_a, ack);
      check_eq("rd_reg_ack", 32'(ack), 0);
      m_ptr = reg_a;
      i2c_start;
    end
    write_byte(8'hD1, ack);
    check_eq("rd_addr_ack", 32'(ack), 0);
    check_eq("rd_busy", 32'(busy), 1);
    for (int k = 0; k < 14; k++) m_buf[k] = m_shadow[k];
    for (int unsigned i = 0; i < n; i++) begin
      if (mid_update && i == 5) begin
        for (int k = 0; k < 14; k++) m_shadow[k] = 8'hFF;
        pulse_sample;
      end
      read_byte(d, (i == n - 1));
      check_eq("rdata", 32'(d), 32'(model_reg(m_ptr)));
      m_ptr = m_ptr + 8'd1;
    end
    check_eq("nack_busy", 32'(busy), 0);
    check_eq("nack_release", 32'(bus.sda_oe_o), 0);
    i2c_stop;
    check_eq("rd_busy_stop", 32'(busy), 0);
  endtask

  function automatic logic [7:0] pick_reg;
    case ($urandom_range(0, 3))
      0:       return 8'h6B;
      1:       return 8'(8'h3B + $urandom_range(0, 13));
      2:       return 8'h75;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic ack;
    model_reset;
    repeat (5) @(negedge clk);
    check_eq("rst_pwr", 32'(pwr), 32'h40);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_oe", 32'(bus.sda_oe_o), 0);
    check_eq("rst_strobe", 32'(strobe), 0);
    rst_n = 1'b1;
    wait_q(2);

    // PWR_MGMT write 0x40 -> 0x00
    wdata_q = '{8'h00};
    txn_write(8'h6B);
    check_eq("pwr_cleared", 32'(pwr), 32'h00);
    check_eq("one_strobe", strobe_pulses, 1);

    // WHO_AM_I via repeated START
    txn_read(1'b1, 8'h75, 1, 1'b0);

    // Sensor burst, shadow update mid-burst must not disturb it
    for (int k = 0; k < 14; k++) m_shadow[k] = 8'(k + 1);
    pulse_sample;
    txn_read(1'b1, 8'h3B, 14, 1'b1);

    // Foreign address: no ACK, no drive, never busy
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start;
    write_byte(8'hD2, ack);
    check_eq("foreign_nack", 32'(ack), 1);
    write_byte(8'h55, ack);
    check_eq("foreign_data_nack", 32'(ack), 1);
    i2c_stop;
    check_eq("foreign_oe_seen", 32'(oe_seen), 0);
    check_eq("foreign_busy_seen", 32'(busy_seen), 0);

    // Pointer wrap 0xFF -> 0x00
    txn_read(1'b1, 8'hFF, 2, 1'b0);
    check_eq("ptr_wrapped", 32'(m_ptr), 32'h01);
    txn_read(1'b0, 8'h00, 1, 1'b0);

    // Reset while target drives a 0 data bit (bit 7 of WHO_AM_I)
    i2c_start;
    write_byte(8'hD0, ack);
    write_byte(8'h75, ack);
    i2c_start;
    write_byte(8'hD1, ack);
    check_eq("rd_bit7_driven", 32'(bus.sda_oe_o), 1);
    m_scl = 1'b1;
    wait_q(1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_oe", 32'(bus.sda_oe_o), 0);
    check_eq("arst_pwr", 32'(pwr), 32'h40);
    check_eq("arst_busy", 32'(busy), 0);
    m_scl = 1'b0;
    wait_q(1);
    m_sda = 1'b1;
    wait_q(1);
    m_scl = 1'b1;
    wait_q(1);
    rst_n = 1'b1;
    model_reset;
    wait_q(2);
    wdata_q = '{8'h07};
    txn_write(8'h6B);
    txn_read(1'b1, 8'h6B, 1, 1'b0);
    txn_read(1'b1, 8'h3B, 2, 1'b0);

    // Randomized transactions against the model
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 14; k++) m_shadow[k] = 8'($urandom);
        pulse_sample;
      end
      case ($urandom_range(0, 3))
        0, 1: begin
          wdata_q.delete();
          for (int unsigned j = 0; j < $urandom_range(1, 3); j++) wdata_q.push_back(8'($urandom));
          txn_write(pick_reg());
        end
        2:       txn_read(1'b1, pick_reg(), $urandom_range(1, 4), 1'b0);
        default: txn_read(1'b0, 8'h00, $urandom_range(1, 3), 1'b0);
      endcase
    end

    check_eq("oe_change_scl_high", oe_viol, 0);
    check_eq("strobe_width", strobe_cycles, strobe_pulses);
    check_eq("strobe_total", strobe_pulses, m_strobes);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
